// File: rtl/alarm_matcher.sv
// alarm_matcher: compares five stored alarm times against the running clock
// on each 1 Hz tick, queues matching slots and services them one at a time
// through a RING / SNOOZE sequence with stop and snooze controls.
module alarm_matcher #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic [7:0] cur_hour,
   input  logic [7:0] cur_min,
   input  logic [7:0] cur_sec,
   input  logic [7:0] A_hour0,
   input  logic [7:0] A_hour1,
   input  logic [7:0] A_hour2,
   input  logic [7:0] A_hour3,
   input  logic [7:0] A_hour4,
   input  logic [7:0] A_min0,
   input  logic [7:0] A_min1,
   input  logic [7:0] A_min2,
   input  logic [7:0] A_min3,
   input  logic [7:0] A_min4,
   input  logic [7:0] A_sec0,
   input  logic [7:0] A_sec1,
   input  logic [7:0] A_sec2,
   input  logic [7:0] A_sec3,
   input  logic [7:0] A_sec4,
   input  logic [4:0] alarm_enable,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic [2:0] ring_id,
   output logic [4:0] active,
   output logic [4:0] pending
);

   localparam int CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECONDS);
   localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECONDS);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RING,
      ST_SNOOZE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_ring_cnt;
   logic [CNT_W-1:0] r_snooze_cnt;
   logic             r_ring;
   logic [2:0]       r_ring_id;
   logic [4:0]       r_active;
   logic [4:0]       r_pending;

   logic [7:0] w_hour [5];
   logic [7:0] w_min  [5];
   logic [7:0] w_sec  [5];
   logic [4:0] w_match;
   logic [4:0] w_candidates;
   logic       w_sel_valid;
   logic [2:0] w_sel_idx;
   logic [4:0] w_sel_onehot;
   logic [4:0] w_take;
   logic [4:0] w_pending_next;
   logic       w_serviced_disabled;

   assign w_hour[0] = A_hour0;
   assign w_hour[1] = A_hour1;
   assign w_hour[2] = A_hour2;
   assign w_hour[3] = A_hour3;
   assign w_hour[4] = A_hour4;
   assign w_min[0]  = A_min0;
   assign w_min[1]  = A_min1;
   assign w_min[2]  = A_min2;
   assign w_min[3]  = A_min3;
   assign w_min[4]  = A_min4;
   assign w_sec[0]  = A_sec0;
   assign w_sec[1]  = A_sec1;
   assign w_sec[2]  = A_sec2;
   assign w_sec[3]  = A_sec3;
   assign w_sec[4]  = A_sec4;

   // Per-slot exact compare, qualified by the tick and the slot's arm bit.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_match[i] = tick_1hz && alarm_enable[i] &&
                      (w_hour[i] == cur_hour) &&
                      (w_min[i]  == cur_min)  &&
                      (w_sec[i]  == cur_sec);
      end
   end

   // Lowest-index armed pending slot is the next one to service.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_sel_valid  = 1'b0;
      w_sel_idx    = 3'd0;
      w_candidates = r_pending & alarm_enable;
      for (int i = 4; i >= 0; i--) begin
         if (w_candidates[i]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = 3'(i);
         end
      end
      w_sel_onehot = 5'b00001 << w_sel_idx;
   end

   // Pending queue: drop the slot taken for service, merge new matches,
   // and clear anything whose arm bit is low.
   always_comb begin
      w_take         = (r_state == ST_IDLE && w_sel_valid) ? w_sel_onehot : 5'b00000;
      w_pending_next = ((r_pending & ~w_take) | w_match) & alarm_enable;
   end

   // Disarming the slot currently being serviced aborts its service.
   assign w_serviced_disabled = |(r_active & ~alarm_enable);

   // Service FSM with registered ring/active/ring_id and the pending queue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_ring_cnt   <= '0;
         r_snooze_cnt <= '0;
         r_ring       <= 1'b0;
         r_ring_id    <= 3'd0;
         r_active     <= 5'b00000;
         r_pending    <= 5'b00000;
      end else begin
         // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
         r_pending <= w_pending_next;
         case (r_state)
            ST_IDLE: begin
               if (w_sel_valid) begin
                  r_state    <= ST_RING;
                  r_ring     <= 1'b1;
                  r_ring_id  <= w_sel_idx;
                  r_active   <= w_sel_onehot;
                  r_ring_cnt <= RING_LOAD;
               end
            end
            ST_RING: begin
               if (w_serviced_disabled || stop) begin
                  r_state  <= ST_IDLE;
                  r_ring   <= 1'b0;
                  r_active <= 5'b00000;
               end else if (snooze) begin
                  r_state      <= ST_SNOOZE;
                  r_ring       <= 1'b0;
                  r_snooze_cnt <= SNOOZE_LOAD;
               end else if (tick_1hz) begin
                  if (r_ring_cnt <= CNT_ONE) begin
                     r_state    <= ST_IDLE;
                     r_ring     <= 1'b0;
                     r_active   <= 5'b00000;
                     r_ring_cnt <= '0;
                  end else begin
                     r_ring_cnt <= r_ring_cnt - CNT_ONE;
                  end
               end
            end
            ST_SNOOZE: begin
               if (w_serviced_disabled || stop) begin
                  r_state  <= ST_IDLE;
                  r_ring   <= 1'b0;
                  r_active <= 5'b00000;
               end else if (tick_1hz) begin
                  if (r_snooze_cnt <= CNT_ONE) begin
                     r_state      <= ST_RING;
                     r_ring       <= 1'b1;
                     r_ring_cnt   <= RING_LOAD;
                     r_snooze_cnt <= '0;
                  end else begin
                     r_snooze_cnt <= r_snooze_cnt - CNT_ONE;
                  end
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_ring   <= 1'b0;
               r_active <= 5'b00000;
            end
         endcase
      end
   end

   assign ring    = r_ring;
   assign ring_id = r_ring_id;
   assign active  = r_active;
   assign pending = r_pending;

endmodule

// File: tb/tb_alarm_matcher.sv
// Self-checking bench for alarm_matcher with RING_SECONDS=3, SNOOZE_SECONDS=2.
module tb_alarm_matcher;

   logic       clock = 1'b0;
   logic       reset;
   logic       tick_1hz;
   logic [7:0] cur_hour, cur_min, cur_sec;
   logic [7:0] A_hour0, A_hour1, A_hour2, A_hour3, A_hour4;
   logic [7:0] A_min0, A_min1, A_min2, A_min3, A_min4;
   logic [7:0] A_sec0, A_sec1, A_sec2, A_sec3, A_sec4;
   logic [4:0] alarm_enable;
   logic       stop, snooze;
   logic       ring;
   logic [2:0] ring_id;
   logic [4:0] active;
   logic [4:0] pending;

   int n_total = 0;
   int n_pass  = 0;

   alarm_matcher #(.RING_SECONDS(3), .SNOOZE_SECONDS(2)) dut (
      .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .A_hour0(A_hour0), .A_hour1(A_hour1), .A_hour2(A_hour2), .A_hour3(A_hour3), .A_hour4(A_hour4),
      .A_min0(A_min0), .A_min1(A_min1), .A_min2(A_min2), .A_min3(A_min3), .A_min4(A_min4),
      .A_sec0(A_sec0), .A_sec1(A_sec1), .A_sec2(A_sec2), .A_sec3(A_sec3), .A_sec4(A_sec4),
      .alarm_enable(alarm_enable), .stop(stop), .snooze(snooze),
      .ring(ring), .ring_id(ring_id), .active(active), .pending(pending)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        tick;
      logic [23:0] t;
      logic [4:0]  en;
      logic        stp;
      logic        snz;
      logic        ring;
      logic [2:0]  id;
      logic [4:0]  act;
      logic [4:0]  pend;
   } vec_t;

   typedef struct packed {
      logic       ring;
      logic [2:0] id;
      logic [4:0] act;
      logic [4:0] pend;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   localparam logic [23:0] T_X    = 24'h120000;
   localparam logic [23:0] T_0730 = 24'h073000;
   localparam logic [23:0] T_0600 = 24'h060000;
   localparam logic [23:0] T_0815 = 24'h081500;
   localparam logic [23:0] T_0900 = 24'h090000;

   function automatic void add(input logic tk, input logic [23:0] t, input logic [4:0] en,
                               input logic stp, input logic snz, input logic rg,
                               input logic [2:0] id, input logic [4:0] act, input logic [4:0] pend);
      vec_t v;
      v.tick = tk; v.t = t; v.en = en; v.stp = stp; v.snz = snz;
      v.ring = rg; v.id = id; v.act = act; v.pend = pend;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   task automatic drive(input logic tk, input logic [23:0] t, input logic [4:0] en,
                        input logic stp, input logic snz);
      tick_1hz     = tk;
      cur_hour     = t[23:16];
      cur_min      = t[15:8];
      cur_sec      = t[7:0];
      alarm_enable = en;
      stop         = stp;
      snooze       = snz;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic rg, input logic [2:0] id,
                            input logic [4:0] act, input logic [4:0] pend);
      check({tag, " ring"},    {7'd0, ring},    {7'd0, rg});
      check({tag, " ring_id"}, {5'd0, ring_id}, {5'd0, id});
      check({tag, " active"},  {3'd0, active},  {3'd0, act});
      check({tag, " pending"}, {3'd0, pending}, {3'd0, pend});
   endtask

   initial begin
      exp_t e;

      // Slot 2 single alarm: pending at tick+1, ring at tick+2, three ticks of ring.
      add(1, T_0730, 5'b00100, 0, 0, 0, 3'd0, 5'b00000, 5'b00100);
      add(0, T_X,    5'b00100, 0, 0, 1, 3'd2, 5'b00100, 5'b00000);
      add(0, T_X,    5'b00100, 0, 0, 1, 3'd2, 5'b00100, 5'b00000);
      add(1, T_X,    5'b00100, 0, 0, 1, 3'd2, 5'b00100, 5'b00000);
      add(1, T_X,    5'b00100, 0, 0, 1, 3'd2, 5'b00100, 5'b00000);
      add(1, T_X,    5'b00100, 0, 0, 0, 3'd2, 5'b00000, 5'b00000);
      add(0, T_X,    5'b00100, 0, 0, 0, 3'd2, 5'b00000, 5'b00000);
      // Slots 0 and 4 match together: slot 0 first, slot 4 back-to-back.
      add(1, T_0600, 5'b10001, 0, 0, 0, 3'd2, 5'b00000, 5'b10001);
      add(0, T_X,    5'b10001, 0, 0, 1, 3'd0, 5'b00001, 5'b10000);
      add(1, T_X,    5'b10001, 0, 0, 1, 3'd0, 5'b00001, 5'b10000);
      add(1, T_X,    5'b10001, 0, 0, 1, 3'd0, 5'b00001, 5'b10000);
      add(1, T_X,    5'b10001, 0, 0, 0, 3'd0, 5'b00000, 5'b10000);
      add(0, T_X,    5'b10001, 0, 0, 1, 3'd4, 5'b10000, 5'b00000);
      add(1, T_X,    5'b10001, 0, 0, 1, 3'd4, 5'b10000, 5'b00000);
      add(1, T_X,    5'b10001, 0, 0, 1, 3'd4, 5'b10000, 5'b00000);
      add(1, T_X,    5'b10001, 0, 0, 0, 3'd4, 5'b00000, 5'b00000);
      // Slot 1 snooze (held level ignored in SNOOZE), re-ring for 3 ticks.
      add(1, T_0815, 5'b00010, 0, 0, 0, 3'd4, 5'b00000, 5'b00010);
      add(0, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(0, T_X,    5'b00010, 0, 1, 0, 3'd1, 5'b00010, 5'b00000);
      add(0, T_X,    5'b00010, 0, 1, 0, 3'd1, 5'b00010, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00010, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      // Slot 1 snooze then stop during SNOOZE: no re-ring.
      add(1, T_0815, 5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00010);
      add(0, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(0, T_X,    5'b00010, 0, 1, 0, 3'd1, 5'b00010, 5'b00000);
      add(0, T_X,    5'b00010, 1, 0, 0, 3'd1, 5'b00000, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      // stop and snooze together while ringing: stop wins.
      add(1, T_0815, 5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00010);
      add(0, T_X,    5'b00010, 0, 0, 1, 3'd1, 5'b00010, 5'b00000);
      add(0, T_X,    5'b00010, 1, 1, 0, 3'd1, 5'b00000, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      add(1, T_X,    5'b00010, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      // Slot 3 disarmed: no match. Then armed, and disarmed mid-RING.
      add(1, T_0900, 5'b00000, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      add(0, T_X,    5'b00000, 0, 0, 0, 3'd1, 5'b00000, 5'b00000);
      add(1, T_0900, 5'b01000, 0, 0, 0, 3'd1, 5'b00000, 5'b01000);
      add(0, T_X,    5'b01000, 0, 0, 1, 3'd3, 5'b01000, 5'b00000);
      add(0, T_X,    5'b00000, 0, 0, 0, 3'd3, 5'b00000, 5'b00000);
      add(0, T_X,    5'b01000, 0, 0, 0, 3'd3, 5'b00000, 5'b00000);

      A_hour0 = 8'h06; A_min0 = 8'h00; A_sec0 = 8'h00;
      A_hour1 = 8'h08; A_min1 = 8'h15; A_sec1 = 8'h00;
      A_hour2 = 8'h07; A_min2 = 8'h30; A_sec2 = 8'h00;
      A_hour3 = 8'h09; A_min3 = 8'h00; A_sec3 = 8'h00;
      A_hour4 = 8'h06; A_min4 = 8'h00; A_sec4 = 8'h00;
      drive(0, T_X, 5'b00000, 0, 0);
      reset = 1'b1;
      repeat (2) step();
      check_all("reset", 1'b0, 3'd0, 5'b00000, 5'b00000);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].tick, vecs[i].t, vecs[i].en, vecs[i].stp, vecs[i].snz);
         e.ring = vecs[i].ring; e.id = vecs[i].id; e.act = vecs[i].act; e.pend = vecs[i].pend;
         sb.push_back(e);
         step();
         e = sb.pop_front();
         check_all($sformatf("vec%0d", i), e.ring, e.id, e.act, e.pend);
      end

      // Reset asserted during SNOOZE with slots 0 and 1 queued.
      A_hour0 = 8'h10; A_min0 = 8'h00; A_sec0 = 8'h00;
      A_hour1 = 8'h10; A_min1 = 8'h00; A_sec1 = 8'h00;
      drive(1, T_0730, 5'b00111, 0, 0); step();
      check_all("rst_seq match", 1'b0, 3'd3, 5'b00000, 5'b00100);
      drive(0, T_X, 5'b00111, 0, 0); step();
      check_all("rst_seq ring", 1'b1, 3'd2, 5'b00100, 5'b00000);
      drive(0, T_X, 5'b00111, 0, 1); step();
      check_all("rst_seq snooze", 1'b0, 3'd2, 5'b00100, 5'b00000);
      drive(1, 24'h100000, 5'b00111, 0, 0); step();
      check_all("rst_seq queued", 1'b0, 3'd2, 5'b00100, 5'b00011);
      drive(0, T_X, 5'b00111, 0, 0);
      #2 reset = 1'b1;
      #1 check_all("rst_seq async", 1'b0, 3'd0, 5'b00000, 5'b00000);
      step();
      reset = 1'b0;
      step();
      check_all("rst_seq after1", 1'b0, 3'd0, 5'b00000, 5'b00000);
      step();
      check_all("rst_seq after2", 1'b0, 3'd0, 5'b00000, 5'b00000);

      // 00:00:00 is a valid alarm time.
      A_hour3 = 8'h00; A_min3 = 8'h00; A_sec3 = 8'h00;
      drive(1, 24'h000000, 5'b01000, 0, 0); step();
      check_all("midnight match", 1'b0, 3'd0, 5'b00000, 5'b01000);
      drive(0, T_X, 5'b01000, 0, 0); step();
      check_all("midnight ring", 1'b1, 3'd3, 5'b01000, 5'b00000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
